// File: rtl/bus_console_target.sv
// bus_console_target: memory-mapped console responder on the shared system bus.
// Decodes a 16-byte window at BASE_ADDR. DATA writes push into a TX FIFO that
// drains to an external byte sink; DATA reads pop an RX FIFO fed by an external
// byte source. STATUS exposes FIFO flags and counts. Every hit gets exactly one
// bus_ready pulse, followed by a one-cycle HOLD so that a request the initiator
// is still holding is not taken twice.
// Optional feature macro: BUS_CONSOLE_RX_EN builds the RX FIFO and RX port.
// Without it, rx_ready is 0, DATA reads return 0 and the RX STATUS fields read 0.
module bus_console_target #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_rd,
  input  logic        bus_wr,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TX, S_RESP, S_HOLD} state_t;

  state_t      state;
  logic        op_wr;
  logic [1:0]  op_sel;
  logic [7:0]  op_byte;
  logic        op_pop;

  logic        req_hit;
  logic [31:0] rd_value;

  // Request decode: rd and wr together count as a write.
  assign req_hit = (bus_rd | bus_wr) && (bus_addr[31:4] == BASE_ADDR[31:4]);

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = (state == S_RESP) && op_wr && (op_sel == 2'd0);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

  // TX storage write.
  // NOTE: FIFO storage is deliberately not reset; the pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= op_byte;
  end

  // TX pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic       rx_nonempty, rx_full;
  logic [7:0] rx_head, rx_count8;
  logic       rx_pop;

  assign rx_pop = (state == S_RESP) && op_pop;

`ifdef BUS_CONSOLE_RX_EN
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_push;

  assign rx_full     = (rx_count == CW'(FIFO_DEPTH));
  assign rx_nonempty = (rx_count != '0);
  assign rx_ready    = !rx_full;
  assign rx_push     = rx_valid & rx_ready;
  assign rx_head     = rx_mem[rx_rd_ptr];
  assign rx_count8   = 8'(rx_count);

  // RX storage write.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // RX pointers and occupancy; a bus pop and a serial push may coincide.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end
`else
  assign rx_full     = 1'b0;
  assign rx_nonempty = 1'b0;
  assign rx_ready    = 1'b0;
  assign rx_head     = 8'h00;
  assign rx_count8   = 8'h00;

  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid, rx_pop};
`endif

  logic unused_bus;
  assign unused_bus = ^{bus_wdata[31:8], bus_addr[1:0]};

  // Read data as seen at the accepting edge.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_value = '0;
    if (!bus_wr) begin
      case (bus_addr[3:2])
        2'd0: if (rx_nonempty) rd_value = {1'b1, 23'b0, rx_head};
        2'd1: rd_value = {8'h00, rx_count8, 8'(tx_count), 4'h0,
                          rx_full, rx_nonempty, tx_empty, tx_full};
        default: rd_value = '0;
      endcase
    end
  end

  // Bus protocol FSM with registered bus_ready / bus_rdata.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state     <= S_IDLE;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      op_wr     <= 1'b0;
      op_sel    <= 2'd0;
      op_byte   <= 8'h00;
      op_pop    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_hit) begin
            op_wr   <= bus_wr;
            op_sel  <= bus_addr[3:2];
            op_byte <= bus_wdata[7:0];
            op_pop  <= !bus_wr && (bus_addr[3:2] == 2'd0) && rx_nonempty;
            if (bus_wr && (bus_addr[3:2] == 2'd0) && tx_full) begin
              state <= S_WAIT_TX;
            end else begin
              state     <= S_RESP;
              bus_ready <= 1'b1;
              bus_rdata <= rd_value;
            end
          end
        end
        S_WAIT_TX: begin
          if (!tx_full) begin
            state     <= S_RESP;
            bus_ready <= 1'b1;
          end
        end
        S_RESP: begin
          bus_ready <= 1'b0;
          bus_rdata <= '0;
          op_pop    <= 1'b0;
          state     <= S_HOLD;
        end
        S_HOLD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_console_target.sv
// Testbench for bus_console_target: directed bus accesses with a scoreboard.
// Drivers push expected bus responses and expected TX bytes into queues; an
// independent monitor pops and compares whenever bus_ready or a TX handshake
// is observed.
`timescale 1ns/1ps
module tb_bus_console_target;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef BUS_CONSOLE_RX_EN
  localparam logic RX_EN = 1'b1;
`else
  localparam logic RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Nrst = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  bus_console_target dut (
    .clk       (clk),
    .Nrst      (Nrst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  int vectors = 0;
  int miscompares = 0;
  int ack_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every bus response and every TX byte against the queues.
  always @(negedge clk) begin
    #1;
    if (bus_ready) begin
      ack_count++;
      if (exp_q.size() == 0) check("unexpected bus_ready", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, bus_rdata, e.data);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) check("unexpected tx byte", 32'd1, 32'd0);
      else check("tx byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One bus access: hold the request until bus_ready, optionally keep holding through HOLD.
  task automatic bus_op(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int exp_lat, input bit hold);
    int  lat;
    bit  seen;
    exp_t e;
    @(negedge clk);
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_rd    = rd;
    bus_wr    = wr;
    e.name = name;
    e.data = exp_data;
    exp_q.push_back(e);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus_ready) seen = 1'b1;
    end
    if (!seen) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else if (exp_lat != 0) begin
      check({name, " latency"}, lat, exp_lat);
    end
    if (hold) begin
      @(negedge clk);
      @(negedge clk);
    end
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_data(input string name, input logic [7:0] b, input int exp_lat, input bit hold);
    tx_q.push_back(b);
    bus_op(name, 1'b0, 1'b1, BASE, {24'h0, b}, 32'h0, exp_lat, hold);
  endtask

  task automatic bus_noack(input string name, input logic [31:0] addr);
    int a0;
    @(negedge clk);
    bus_addr = addr;
    bus_rd   = 1'b1;
    a0 = ack_count;
    repeat (10) @(negedge clk);
    #2;
    check(name, ack_count - a0, 32'd0);
    bus_rd = 1'b0;
  endtask

  task automatic drain(input int n);
    @(negedge clk);
    tx_ready = 1'b1;
    repeat (n) @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    int a0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset bus_ready", {31'b0, bus_ready}, 32'd0);
    check("reset bus_rdata", bus_rdata, 32'd0);
    check("reset tx_valid", {31'b0, tx_valid}, 32'd0);
    check("reset tx_data", {24'b0, tx_data}, 32'd0);
    check("reset rx_ready", {31'b0, rx_ready}, {31'b0, RX_EN});
    Nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Single write, then TX output and STATUS
    write_data("wr 0x41", 8'h41, 1, 1'b0);
    check("tx_valid after push", {31'b0, tx_valid}, 32'd1);
    check("tx_data after push", {24'b0, tx_data}, 32'h41);
    bus_op("status one byte", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0000_0100, 1, 1'b0);
    drain(1);
    check("tx_valid drained", {31'b0, tx_valid}, 32'd0);

    // Fill TX, 17th write stalls in WAIT_TX until one byte leaves
    for (int i = 0; i < 16; i++) write_data("wr fill", 8'(i), 1, 1'b0);
    a0 = ack_count;
    fork
      write_data("wr 17th", 8'd16, 0, 1'b0);
      begin
        repeat (6) @(negedge clk);
        check("wait_tx stall", ack_count - a0, 32'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("wait_tx not yet ready", {31'b0, bus_ready}, 32'd0);
        @(negedge clk);
        check("wait_tx release timing", {31'b0, bus_ready}, 32'd1);
      end
    join
    bus_op("status full", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0000_1001, 1, 1'b0);
    drain(16);
    check("tx empty after drain", {31'b0, tx_valid}, 32'd0);

    // RX path
`ifdef BUS_CONSOLE_RX_EN
    @(negedge clk);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    bus_op("status rx one", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0001_0006, 1, 1'b0);
    bus_op("rd rx 0x5A", 1'b1, 1'b0, BASE, 32'h0, 32'h8000_005A, 1, 1'b0);
    bus_op("rd rx empty", 1'b1, 1'b0, BASE, 32'h0, 32'h0000_0000, 1, 1'b0);
    bus_op("status rx underflow", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0000_0002, 1, 1'b0);
    @(negedge clk);
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("rx_ready when full", {31'b0, rx_ready}, 32'd0);
    bus_op("status rx full", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0010_000E, 1, 1'b0);
    bus_op("rd rx first of 16", 1'b1, 1'b0, BASE, 32'h0, 32'h8000_00C0, 1, 1'b0);
    check("rx_ready after pop", {31'b0, rx_ready}, 32'd1);
`else
    @(negedge clk);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("rx_ready tied low", {31'b0, rx_ready}, 32'd0);
    bus_op("rd data no rx", 1'b1, 1'b0, BASE, 32'h0, 32'h0000_0000, 1, 1'b0);
    bus_op("status no rx", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0000_0002, 1, 1'b0);
`endif

    // Window decode and reserved registers
    bus_noack("no ack outside window", BASE + 32'h20);
    bus_op("rd reserved 0x8", 1'b1, 1'b0, BASE + 32'h8, 32'h0, 32'h0, 1, 1'b0);
    bus_op("wr reserved 0xC", 1'b0, 1'b1, BASE + 32'hC, 32'hFF, 32'h0, 1, 1'b0);

    // rd+wr together is a write; held request pushes once
    tx_q.push_back(8'h33);
    bus_op("rd+wr as write", 1'b1, 1'b1, BASE, 32'h33, 32'h0, 1, 1'b0);
    write_data("wr held through hold", 8'h77, 1, 1'b1);
    bus_op("status two bytes", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0000_0200, 1, 1'b0);
    drain(2);

    // Reset during WAIT_TX drops the access
    for (int i = 0; i < 16; i++) write_data("wr refill", 8'(8'h80 + i), 1, 1'b0);
    @(negedge clk);
    bus_addr  = BASE;
    bus_wdata = 32'hEE;
    bus_wr    = 1'b1;
    a0 = ack_count;
    repeat (5) @(negedge clk);
    Nrst   = 1'b0;
    bus_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("tx_valid in reset", {31'b0, tx_valid}, 32'd0);
    Nrst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("no ack across reset", ack_count - a0, 32'd0);
    tx_q.delete();
    bus_op("status after reset", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'h0000_0002, 1, 1'b0);

    repeat (3) @(negedge clk);
    #2;
    check("scoreboard empty", exp_q.size() + tx_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_console_target.md
# bus_console_target

Memory-mapped console responder on the shared system bus, the target end of the same `bus_rd`/`bus_wr`/`bus_ready` protocol the instruction and data caches initiate. It decodes a small address window, buffers outbound bytes in a TX FIFO and inbound bytes in an RX FIFO, and exchanges them with an external byte-stream port through valid/ready handshakes. It sits beside the block RAM on the bus. Its `bus_rdata` and `bus_ready` are OR-combined with the other targets.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000: window base; the window is 16 bytes and aligned.
- `FIFO_DEPTH`, default 16: entries per FIFO; must be a power of two, 2..128.

Ports:
- `clk` in 1: system clock; single clock domain.
- `Nrst` in 1: reset, asynchronous and active-low.
- `bus_addr` in 32: byte address; only word accesses are defined.
- `bus_wdata` in 32: write data.
- `bus_rd` in 1: read request.
- `bus_wr` in 1: write request.
- `bus_rdata` out 32: read data; all zeros except in the response cycle.
- `bus_ready` out 1: one-cycle completion pulse; 0 except in the response cycle.
- `tx_data` out 8: head byte of the TX FIFO.
- `tx_valid` out 1: TX FIFO is non-empty.
- `tx_ready` in 1: sink accepts `tx_data` this cycle.
- `rx_data` in 8: inbound byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: RX FIFO is not full.

## Operation
- Window hit: `bus_addr[31:4] == BASE_ADDR[31:4]`. Addresses outside the window get no response; outputs stay 0.
- Register map, selected by `bus_addr[3:2]`:
  - 0 DATA. A write pushes `bus_wdata[7:0]` into TX. A read pops RX and returns {rx_nonempty at bit 31, 23'b0, byte}. A read with RX empty returns 0 and does not pop.
  - 1 STATUS, read-only: [0] tx_full, [1] tx_empty, [2] rx_nonempty, [3] rx_full, [15:8] tx_count, [23:16] rx_count.
  - 2–3: a read returns 0, a write is ignored; the access is still acknowledged.
- `bus_rd` and `bus_wr` asserted together: treated as a write.
- States:
  - IDLE: a request that hits the window moves to RESP. The exception is a DATA write while TX is full, which moves to WAIT_TX.
  - WAIT_TX: stays while TX is full. Leaves on the first cycle TX is not full and moves to RESP.
  - RESP: `bus_ready`=1. `bus_rdata` carries registered read data. The FIFO push or pop takes effect at the end of this cycle. Next state is HOLD.
  - HOLD: ignores the bus for one cycle so that a request still held by the initiator is not double-counted. Next state is IDLE.
- TX FIFO:
  - Pop when `tx_valid & tx_ready`.
  - A bus push and a serial pop in the same cycle are both honoured; the count is unchanged.
- RX FIFO:
  - Push when `rx_valid & rx_ready`.
  - A bus pop and a serial push in the same cycle are both honoured.
- Read pointers and write pointers wrap modulo `FIFO_DEPTH`. Counts are log2(FIFO_DEPTH)+1 bits wide and zero-extended into STATUS.

## Timing
- Reset (`Nrst`=0, at any time including mid-transaction):
  - FIFOs empty, state IDLE.
  - `bus_ready`=0, `bus_rdata`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=1.
  - An in-flight access is dropped without a response.
- Latency: request sampled in IDLE at edge N gives `bus_ready` high in cycle N+1. The next request can be accepted at edge N+3.
- A DATA write while TX is full: `bus_ready` arrives one cycle after TX first shows not-full.
- STATUS read data is sampled at the accepting edge. FIFO activity during RESP does not change it.
- `tx_valid` rises the cycle after the push edge. `rx_ready` falls the cycle after the RX FIFO becomes full.
- The initiator holds its address and data until it sees `bus_ready`.

## Configuration
- `BUS_CONSOLE_RX_EN` defined: the RX FIFO and the RX port logic are built.
- `BUS_CONSOLE_RX_EN` undefined:
  - No RX storage; `rx_ready` is tied to 0 and `rx_data` is ignored.
  - DATA reads return 0.
  - STATUS[2], [3] and [23:16] read 0.
  - The TX path and the bus protocol are unchanged.

## Test plan
- Reset, then write 0x41 to DATA with `tx_ready`=0 -> `bus_ready` pulses 1 cycle later; `tx_valid`=1 and `tx_data`=0x41 the next cycle; STATUS reads 0x0000_0100.
- Write 17 bytes with `tx_ready`=0 -> 16 acknowledged, the 17th held in WAIT_TX; pulse `tx_ready` one cycle -> `bus_ready` arrives next cycle, tx_count=16, first byte out is 0x00 of sequence 0..16.
- Present 0x5A on RX, then read DATA -> 0x8000_005A; read again -> 0x0000_0000 with no underflow.
- Read at BASE_ADDR+0x20 -> no `bus_ready` within 10 cycles; read at offset 0x8 -> ready, data 0.
- Hold `bus_wr` high across RESP and HOLD -> exactly one push.
- Assert `Nrst` during WAIT_TX -> no ready pulse, all counts 0 after release.
